debug_unit: RTL and testbench

- Front-panel debug controller that sits directly upstream of the multicycle CPU core.
- Produces the core's `run` gate and `ProbeAddress` from board switches and buttons.
- Selects which probe word (register file or data memory) is shown on the display.
- Supports continuous run, exact single-cycle stepping, and address browsing. Includes synchronisers, debouncers and an executed-cycle counter.

---
 rtl/debug_unit.sv | 160 ++++++++++++++++
 tb/tb_debug_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// debug_unit: front-panel debug controller placed ahead of the multicycle CPU.
// It turns board switches and buttons into the CPU clock enable (run) and a
// browse address. It also picks the probe word that goes to the display.
//
// Ports
//   CLK          system clock; the CPU clock is CLK & run
//   reset        asynchronous, active-high; clears all state
//   cont         switch: 1 = continuous run, 0 = step mode
//   step         button: grant exactly one CPU edge per press (step mode)
//   inc, dec     buttons: ProbeAddress +1 / -1
//   mem          switch: 1 = browse data memory, 0 = browse register file
//   ProbeRegData register-file word at ProbeAddress
//   ProbeMemData data-memory word at ProbeAddress
//   run          CPU clock enable, changes only on the falling edge of CLK
//   ProbeAddress browse address
//   DisplayData  word for the 7-segment display
//   LED          mirror of ProbeAddress
//   CycleCount   CPU clock edges granted since reset (wraps at 16 bits)
module debug_unit #(
  parameter int DIGIT     = 32,
  parameter int DEBUGSIZE = 8,
  parameter int DEBOUNCE  = 16,
  parameter int REGCOUNT  = 32
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 cont,
  input  logic                 step,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 mem,
  input  logic [DIGIT-1:0]     ProbeRegData,
  input  logic [DIGIT-1:0]     ProbeMemData,
  output logic                 run,
  output logic [DEBUGSIZE-1:0] ProbeAddress,
  output logic [DIGIT-1:0]     DisplayData,
  output logic [DEBUGSIZE-1:0] LED,
  output logic [15:0]          CycleCount
);

  localparam int                   CW       = $clog2(DEBOUNCE);
  localparam logic [CW-1:0]        CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [DEBUGSIZE-1:0] REG_MASK = DEBUGSIZE'(REGCOUNT - 1);

  // Address wrap: register mode folds into the register-file range, memory
  // mode uses the natural DEBUGSIZE-bit wrap.
  function automatic logic [DEBUGSIZE-1:0] wrap_addr(
    input logic [DEBUGSIZE-1:0] a,
    input logic                 reg_mode
  );
    return reg_mode ? (a & REG_MASK) : a;
  endfunction

  // Synchroniser bit order: {mem, dec, inc, step, cont}
  logic [4:0]         sync_p0, sync_p1;
  logic               vld_p0, vld_p1;
  logic               cont_s, mem_s;
  logic [2:0]         btn_s;           // {dec, inc, step}
  logic [2:0]         db_lvl;
  logic [2:0]         armed;
  logic [2:0]         press;
  logic [2:0][CW-1:0] db_cnt;
  logic               req;
  logic [DEBUGSIZE-1:0] addr_nx;

  assign cont_s = sync_p1[0];
  assign btn_s  = sync_p1[3:1];
  assign mem_s  = sync_p1[4];

  // ---- stage p0/p1: two-flop synchronisers ----
  // vld_p1 marks when sync_p1 holds a real sample rather than reset zeros.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      sync_p0 <= {mem, dec, inc, step, cont};
      sync_p1 <= sync_p0;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
    end
  end

  // ---- debounce and press detection ----
  // A button only becomes armed once it has been seen released after reset.
  // A button held through reset therefore never produces a press pulse.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      db_lvl <= '0;
      armed  <= '0;
      press  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (btn_s[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_cnt[i] <= '0;
          db_lvl[i] <= btn_s[i];
          press[i]  <= btn_s[i] & armed[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
        if (vld_p1 && !btn_s[i]) begin
          armed[i] <= 1'b1;
        end
      end
    end
  end

  // ---- run request and gate ----
  // A step press while cont_s is high is absorbed: the gate is open anyway.
  assign req = cont_s | (~cont_s & press[0]);

  // Loaded on the falling edge so run is steady through the whole high phase
  // and CLK & run cannot glitch.
  always_ff @(negedge CLK or posedge reset) begin
    if (reset) begin
      run <= 1'b0;
    end else begin
      run <= req;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      CycleCount <= '0;
    end else if (run) begin
      CycleCount <= CycleCount + 16'd1;
    end
  end

  // ---- browse address ----
  // Masking whenever mem_s is low also folds a memory-range address into
  // the register range on the first cycle after mem falls.
  always_comb begin
    addr_nx = ProbeAddress;
    if (press[1] && !press[2]) begin
      addr_nx = ProbeAddress + DEBUGSIZE'(1);
    end else if (press[2] && !press[1]) begin
      addr_nx = ProbeAddress - DEBUGSIZE'(1);
    end
    addr_nx = wrap_addr(addr_nx, !mem_s);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ProbeAddress <= '0;
    end else begin
      ProbeAddress <= addr_nx;
    end
  end

  assign LED         = ProbeAddress;
  assign DisplayData = mem_s ? ProbeMemData : ProbeRegData;

endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit: randomized and directed stimulus for debug_unit. A queue-based
// behavioural model predicts run, CycleCount, ProbeAddress, LED and
// DisplayData. These are compared after every rising edge. Directed literal
// checks cover reset, step latency, bounce rejection, address wrap and
// continuous run.
module tb_debug_unit;
  localparam int DIGIT     = 32;
  localparam int DEBUGSIZE = 8;
  localparam int DEBOUNCE  = 16;
  localparam int REGCOUNT  = 32;

  logic                 CLK = 1'b0;
  logic                 reset, cont, step, inc, dec, mem;
  logic [DIGIT-1:0]     ProbeRegData, ProbeMemData, DisplayData;
  logic                 run;
  logic [DEBUGSIZE-1:0] ProbeAddress, LED;
  logic [15:0]          CycleCount;

  int n_cmp = 0;
  int n_fail = 0;

  debug_unit #(
    .DIGIT(DIGIT), .DEBUGSIZE(DEBUGSIZE), .DEBOUNCE(DEBOUNCE), .REGCOUNT(REGCOUNT)
  ) dut (
    .CLK(CLK), .reset(reset), .cont(cont), .step(step), .inc(inc), .dec(dec),
    .mem(mem), .ProbeRegData(ProbeRegData), .ProbeMemData(ProbeMemData),
    .run(run), .ProbeAddress(ProbeAddress), .DisplayData(DisplayData),
    .LED(LED), .CycleCount(CycleCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge CLK);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      1: step = v;
      2: inc  = v;
      default: dec = v;
    endcase
  endtask

  task automatic press_btn(input int b);
    set_btn(b, 1'b1);
    cyc(DEBOUNCE + 6);
    set_btn(b, 1'b0);
    cyc(DEBOUNCE + 6);
  endtask

  // Behavioural model. Input index: 0 cont, 1 step, 2 inc, 3 dec, 4 mem.
  // Button index: 0 step, 1 inc, 2 dec.
  // A synchronised input is the raw level from two edges earlier.
  // A button level is accepted once the last DEBOUNCE synced samples all
  // disagree with it. A press counts only if the button has been seen
  // released since reset. A CPU edge is granted at an edge when the request
  // formed after the previous edge was high.
  bit raw_q[5][$];
  bit syn_q[3][$];
  bit m_db[3];
  bit m_arm[3];
  bit m_pls[3];
  int m_n, m_cnt, m_addr;
  bit m_req, m_run, m_mem;

  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) raw_q[i].delete();
      for (int b = 0; b < 3; b++) begin
        syn_q[b].delete();
        m_db[b]  = 1'b0;
        m_arm[b] = 1'b0;
        m_pls[b] = 1'b0;
      end
      m_n = 0; m_cnt = 0; m_addr = 0;
      m_req = 1'b0; m_run = 1'b0; m_mem = 1'b0;
    end else begin
      bit raw[5];
      bit syn[5];
      int modw;
      int sz;
      bit nxt;
      bit diff_all;
      raw[0] = cont; raw[1] = step; raw[2] = inc; raw[3] = dec; raw[4] = mem;
      for (int i = 0; i < 5; i++) syn[i] = (m_n >= 2) ? raw_q[i][m_n-2] : 1'b0;
      m_run = m_req;
      if (m_req) m_cnt = (m_cnt + 1) % 65536;
      modw = syn[4] ? (1 << DEBUGSIZE) : REGCOUNT;
      m_addr = m_addr + int'(m_pls[1]) - int'(m_pls[2]);
      m_addr = ((m_addr % modw) + modw) % modw;
      for (int b = 0; b < 3; b++) begin
        nxt = 1'b0;
        syn_q[b].push_back(syn[b+1]);
        sz = syn_q[b].size();
        if (sz >= DEBOUNCE) begin
          diff_all = 1'b1;
          for (int k = 1; k <= DEBOUNCE; k++)
            if (syn_q[b][sz-k] == m_db[b]) diff_all = 1'b0;
          if (diff_all) begin
            nxt = !m_db[b] && m_arm[b];
            m_db[b] = !m_db[b];
          end
        end
        if (m_n >= 2 && !syn[b+1]) m_arm[b] = 1'b1;
        m_pls[b] = nxt;
      end
      for (int i = 0; i < 5; i++) raw_q[i].push_back(raw[i]);
      m_n++;
      m_mem = (m_n >= 2) ? raw_q[4][m_n-2] : 1'b0;
      m_req = ((m_n >= 2) ? raw_q[0][m_n-2] : 1'b0) | m_pls[0];
    end
  end

  always @(posedge CLK) begin
    #1;
    if (reset === 1'b0) begin
      chk("run", 32'(run), 32'(m_run));
      chk("cycle_count", 32'(CycleCount), 32'(m_cnt));
      chk("probe_address", 32'(ProbeAddress), 32'(m_addr));
      chk("led", 32'(LED), 32'(m_addr));
      chk("display", DisplayData, m_mem ? ProbeMemData : ProbeRegData);
    end
  end

  initial begin
    int lat, c0, c1;
    logic [15:0] cdiff;
    reset = 1'b1; cont = 1'b0; step = 1'b0; inc = 1'b0; dec = 1'b0; mem = 1'b0;
    ProbeRegData = '0; ProbeMemData = '0;

    // step held through reset release
    step = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(40);
    chk("held_reset_run", 32'(run), 32'd0);
    chk("held_reset_count", 32'(CycleCount), 32'd0);
    chk("held_reset_addr", 32'(ProbeAddress), 32'd0);
    step = 1'b0;
    cyc(30);
    chk("held_release_count", 32'(CycleCount), 32'd0);

    // clean step press: latency, then exactly one edge
    step = 1'b1;
    lat = 0;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      @(posedge CLK); #1;
      if (run) lat = i;
    end
    chk("step_latency", 32'(lat), 32'(DEBOUNCE + 3));
    cyc(5);
    chk("step1_count", 32'(CycleCount), 32'd1);
    step = 1'b0;
    cyc(25);
    press_btn(1);
    chk("step2_count", 32'(CycleCount), 32'd2);

    // bouncing step, then settles high
    for (int i = 0; i < 40; i++) begin
      step = ((i / 3) % 2 == 0);
      cyc(1);
    end
    step = 1'b1;
    cyc(30);
    chk("bounce_count", 32'(CycleCount), 32'd3);
    step = 1'b0;
    cyc(25);
    chk("bounce_release_count", 32'(CycleCount), 32'd3);

    // address wrap in both modes
    mem = 1'b0;
    press_btn(3);
    chk("dec_wrap_reg", 32'(ProbeAddress), 32'd31);
    press_btn(2);
    chk("inc_wrap_reg", 32'(ProbeAddress), 32'd0);
    mem = 1'b1;
    cyc(5);
    press_btn(3);
    chk("dec_wrap_mem", 32'(ProbeAddress), 32'd255);
    inc = 1'b1; dec = 1'b1;
    cyc(25);
    inc = 1'b0; dec = 1'b0;
    cyc(25);
    chk("inc_dec_same", 32'(ProbeAddress), 32'd255);
    for (int i = 0; i < 55; i++) press_btn(3);
    chk("addr_200", 32'(ProbeAddress), 32'd200);

    // mem falls: address folds to 200 mod 32, display follows at once
    ProbeMemData = 32'hDEADBEEF;
    ProbeRegData = 32'h00000005;
    cyc(1);
    chk("display_mem", DisplayData, 32'hDEADBEEF);
    mem = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(posedge CLK); #1;
      if (ProbeAddress != 8'd200) lat = i;
    end
    chk("mem_drop_addr", 32'(ProbeAddress), 32'd8);
    chk("mem_drop_led", 32'(LED), 32'd8);
    chk("mem_drop_display", DisplayData, 32'h00000005);

    // continuous run for 100 edges with a step press that must not add edges
    cont = 1'b1;
    cyc(5);
    @(posedge CLK); #1;
    c0 = int'(CycleCount);
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #3;
      step = (i >= 10 && i < 50);
    end
    cdiff = CycleCount - 16'(c0);
    chk("cont_100", 32'(cdiff), 32'd100);
    chk("cont_run", 32'(run), 32'd1);
    cont = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      @(negedge CLK); #1;
      if (!run) lat = i;
    end
    chk("cont_stop_latency", 32'(lat), 32'd3);
    c1 = int'(CycleCount);
    cyc(10);
    chk("stopped_count", 32'(CycleCount), 32'(c1));

    // asynchronous reset while running
    cont = 1'b1;
    cyc(10);
    @(posedge CLK); #2;
    reset = 1'b1;
    #1;
    chk("async_reset_run", 32'(run), 32'd0);
    chk("async_reset_count", 32'(CycleCount), 32'd0);
    chk("async_reset_addr", 32'(ProbeAddress), 32'd0);
    cyc(3);
    cont = 1'b0;
    reset = 1'b0;
    cyc(5);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ProbeRegData = $urandom;
      ProbeMemData = $urandom;
      if ($urandom_range(0, 79) == 0) cont = ~cont;
      if ($urandom_range(0, 59) == 0) mem  = ~mem;
      if ($urandom_range(0, 24) == 0) step = ~step;
      if ($urandom_range(0, 24) == 0) inc  = ~inc;
      if ($urandom_range(0, 24) == 0) dec  = ~dec;
      if (i == 1500) begin
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
      end
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
